// File: rtl/counter_scheduler_pkg.sv
// Shared types and helpers for counter_scheduler.
// Build option COUNTER_SCHEDULER_TRACE_EN is consumed by the top module only.
package counter_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_e;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after rr_ptr, with wrap.
module rr_arbiter
    import counter_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   index
);

    logic              found;
    int unsigned       cand;
    logic [IDX_W-1:0]  cidx;

    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr) + i) % NUM_REQ;
            cidx = IDX_W'(cand);
            if (!found && req[cidx]) begin
                found      = 1'b1;
                gnt[cidx]  = 1'b1;
                index      = cidx;
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one stop-value counter among NUM_REQ requesters.
// Define COUNTER_SCHEDULER_TRACE_EN to print grant/done/abort trace messages.
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned STOP_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_l,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*STOP_WIDTH-1:0] req_stop,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic [STOP_WIDTH-1:0]         cur_count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e            state;
    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        next_ptr;
    logic [STOP_WIDTH-1:0]   ctr;
    logic [STOP_WIDTH-1:0]   stop_q;
    logic [STOP_WIDTH-1:0]   win_stop;
    logic                    owner_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .index  (arb_idx)
    );

    always_comb begin
        win_stop = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == arb_idx) begin
                win_stop = req_stop[i*STOP_WIDTH +: STOP_WIDTH];
            end
        end
    end

    assign owner_req = req[owner];
    assign next_ptr  = IDX_W'(rr_next(32'(owner), NUM_REQ));
    assign cur_count = ctr;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            ctr    <= '0;
            stop_q <= '0;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        grant  <= arb_gnt;
                        owner  <= arb_idx;
                        stop_q <= win_stop;
                        ctr    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef COUNTER_SCHEDULER_TRACE_EN
                        $display("counter_scheduler: grant %0d stop %0d", arb_idx, win_stop);
`endif
                    end
                end
                RUN: begin
                    // Abort takes priority over completion: a dropped request never sees done.
                    if (!owner_req) begin
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
`ifdef COUNTER_SCHEDULER_TRACE_EN
                        $display("counter_scheduler: abort %0d", owner);
`endif
                    end else if (ctr == stop_q) begin
                        done   <= grant;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= DONE;
`ifdef COUNTER_SCHEDULER_TRACE_EN
                        $display("counter_scheduler: done %0d", owner);
`endif
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset_l) $onehot0(grant));
    a_done_onehot0:  assert property (@(posedge clk) disable iff (!reset_l) $onehot0(done));

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler with a queue-based grant/done scoreboard.
module tb_counter_scheduler;

    localparam int NR = 4;
    localparam int SW = 4;

    logic              clk      = 1'b0;
    logic              reset_l  = 1'b0;
    logic [NR-1:0]     req      = '0;
    logic [NR*SW-1:0]  req_stop = '0;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic [SW-1:0]     cur_count;

    typedef struct {
        logic [NR-1:0] who;
        int            len;
    } done_t;

    logic [NR-1:0] exp_grant_q[$];
    done_t         exp_done_q[$];

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            last_done_cyc = 0;
    int            glen  = 0;
    bit            check_gap = 1'b0;
    logic [NR-1:0] prev_grant = '0;

    counter_scheduler #(
        .NUM_REQ    (NR),
        .STOP_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .req       (req),
        .req_stop  (req_stop),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .cur_count (cur_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: pops expected grant owners and done records as the DUT presents them.
    always @(negedge clk) begin
        logic [NR-1:0] eg;
        done_t         ed;
        cyc++;
        if (!reset_l) begin
            prev_grant = '0;
            glen       = 0;
        end else begin
            check("grant_onehot0", int'($onehot0(grant)), 1);
            check("done_onehot0", int'($onehot0(done)), 1);
            if (grant != '0) begin
                if (grant != prev_grant) begin
                    glen = 1;
                    if (exp_grant_q.size() == 0) begin
                        check("grant_unexpected", int'(grant), 0);
                    end else begin
                        eg = exp_grant_q.pop_front();
                        check("grant_owner", int'(grant), int'(eg));
                    end
                    if (check_gap) check("grant_gap", cyc - last_done_cyc, 2);
                end else begin
                    glen++;
                end
            end
            if (done != '0) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", int'(done), 0);
                end else begin
                    ed = exp_done_q.pop_front();
                    check("done_owner", int'(done), int'(ed.who));
                    check("grant_len", glen, ed.len);
                end
                last_done_cyc = cyc;
            end
            prev_grant = grant;
        end
    end

    task automatic set_stop(input int i, input logic [SW-1:0] v);
        req_stop[i*SW +: SW] = v;
    endtask

    task automatic push_run(input logic [NR-1:0] who, input int len);
        exp_grant_q.push_back(who);
        exp_done_q.push_back('{who: who, len: len});
    endtask

    task automatic wait_done(output logic [NR-1:0] d);
        d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done != '0) begin
                d = done;
                return;
            end
        end
        fail("wait_done");
    endtask

    task automatic wait_count(input int v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(cur_count) == v && grant != '0) return;
        end
        fail("wait_count");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] d;
        int            nd;

        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(cur_count), 0);
        reset_l = 1'b1;
        @(negedge clk);

        // Single run, stop 3
        set_stop(0, 4'd3);
        push_run(4'b0001, 4);
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_count", int'(cur_count), k);
            check("t1_busy", int'(busy), 1);
        end
        @(negedge clk);
        check("t1_done", int'(done), 1);
        req = '0;
        @(negedge clk);
        check("t1_done_pulse", int'(done), 0);
        check("t1_busy_low", int'(busy), 0);
        check("t1_count_hold", int'(cur_count), 3);

        // Zero stop
        set_stop(1, 4'd0);
        push_run(4'b0010, 1);
        req = 4'b0010;
        wait_done(d);
        check("t2_done", int'(d), 2);
        check("t2_grant_clear", int'(grant), 0);
        req = '0;
        repeat (2) @(negedge clk);

        // Round-robin from a fresh pointer
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        for (int i = 0; i < NR; i++) set_stop(i, 4'd1);
        push_run(4'b0001, 2);
        push_run(4'b0010, 2);
        push_run(4'b0100, 2);
        push_run(4'b1000, 2);
        push_run(4'b0001, 2);
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_done(d);
            if (r == 0) check_gap = 1'b1;
            if (r == 4) req = '0;
        end
        check_gap = 1'b0;
        repeat (3) @(negedge clk);

        // Abort of requester 2; pointer now 1, so 2 wins, then 3, then 0
        set_stop(0, 4'd1);
        set_stop(2, 4'd7);
        set_stop(3, 4'd2);
        exp_grant_q.push_back(4'b0100);
        push_run(4'b1000, 3);
        push_run(4'b0001, 2);
        req = 4'b1101;
        wait_count(3);
        req[2] = 1'b0;
        @(negedge clk);
        check("t4_abort_grant", int'(grant), 0);
        check("t4_abort_done", int'(done), 0);
        check("t4_abort_busy", int'(busy), 0);
        wait_done(d);
        check("t4_next_done", int'(d), 8);
        req[3] = 1'b0;
        wait_done(d);
        check("t4_wrap_done", int'(d), 1);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Max stop; mid-run req_stop change is ignored
        set_stop(1, 4'd15);
        push_run(4'b0010, 16);
        req = 4'b0010;
        wait_count(5);
        set_stop(1, 4'd2);
        wait_done(d);
        check("t5_done", int'(d), 2);
        check("t5_count_max", int'(cur_count), 15);
        req = '0;
        repeat (3) @(negedge clk);

        // Async reset mid-run
        set_stop(2, 4'd9);
        exp_grant_q.push_back(4'b0100);
        req = 4'b0100;
        wait_count(5);
        #2 reset_l = 1'b0;
        #1;
        check("t6_grant", int'(grant), 0);
        check("t6_done", int'(done), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_count", int'(cur_count), 0);
        req = '0;
        @(negedge clk);
        reset_l = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done != '0) nd++;
        end
        check("t6_no_done", nd, 0);

        check("grant_q_empty", exp_grant_q.size(), 0);
        check("done_q_empty", exp_done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
